// File: rtl/fir_cap_pkg.sv
// rtl/fir_cap_pkg.sv - shared types and defaults for the FIR output capture block
package fir_cap_pkg;

  localparam int DEFAULT_DATA_W = 26;
  localparam int DEFAULT_DEPTH  = 256;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  typedef logic [DEFAULT_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_cap_ram.sv
// rtl/fir_cap_ram.sv - simple dual-port synchronous RAM, read-before-write, registered read
module fir_cap_ram
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; sampling before the write lands gives old data on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_out_capture.sv
// rtl/fir_out_capture.sv - FIR output capture engine; FIR_CAP_CHECKSUM_EN adds an XOR checksum output
module fir_out_capture
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int SKIP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
`ifdef FIR_CAP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done,
  output logic              overrun
);

  localparam int SKIP_W = 9;
  localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [ADDR_W:0]   COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic [SKIP_W-1:0] skip_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              run_start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and write strobe; clear overrides everything else.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    run_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_nxt = (SKIP > 0) ? ST_SKIP : ST_CAPTURE;
        end
      end
      ST_SKIP: begin
        in_ready = 1'b1;
        if (in_valid && (skip_cnt == SKIP_LAST)) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (count == COUNT_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        in_ready = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (clear) begin
      state_nxt = ST_IDLE;
      wr_en     = 1'b0;
      run_start = 1'b0;
    end
  end

  // Run counters, sticky overrun and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt <= '0;
      wr_addr  <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (clear) begin
        skip_cnt <= '0;
        wr_addr  <= '0;
        count    <= '0;
        overrun  <= 1'b0;
      end else begin
        if (run_start) begin
          skip_cnt <= '0;
          wr_addr  <= '0;
          count    <= '0;
        end
        if ((state == ST_SKIP) && in_valid) begin
          skip_cnt <= skip_cnt + 1'b1;
        end
        if (wr_en) begin
          wr_addr <= wr_addr + 1'b1;
          count   <= count + 1'b1;
        end
        if ((state == ST_DONE) && in_valid) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign done = (state == ST_DONE);

`ifdef FIR_CAP_CHECKSUM_EN
  // Running XOR of every stored word, visible the cycle after each write.
  always_ff @(posedge clk) begin
    if (reset || clear || run_start) begin
      checksum <= '0;
    end else if (wr_en) begin
      checksum <= checksum ^ in_data;
    end
  end
`endif

  fir_cap_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_fir_out_capture.sv
// tb/tb_fir_out_capture.sv - directed self-checking bench for fir_out_capture
module tb_fir_out_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start10 = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [25:0] in_data = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;

  logic        in_ready, rd_valid, done, overrun;
  logic [25:0] rd_data;
  logic [8:0]  count;
  logic        in_ready10, rd_valid10, done10, overrun10;
  logic [25:0] rd_data10;
  logic [8:0]  count10;
`ifdef FIR_CAP_CHECKSUM_EN
  logic [25:0] checksum, checksum10;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fir_out_capture dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count),
`ifdef FIR_CAP_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done), .overrun(overrun)
  );

  fir_out_capture #(.SKIP(10)) dut_skip (
    .clk(clk), .reset(reset), .start(start10), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready10),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data10), .rd_valid(rd_valid10),
    .count(count10),
`ifdef FIR_CAP_CHECKSUM_EN
    .checksum(checksum10),
`endif
    .done(done10), .overrun(overrun10)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    nvec++; if (rd_data !== 26'd0) begin nerr++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    nvec++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    nvec++; if (count !== 9'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_skip0_stream;
    start = 1'b1;
    tick;
    start = 1'b0;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL capture_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = 26'(i);
      tick;
      if (i == 254) begin
        nvec++; if (count !== 9'd255 || done !== 1'b0) begin nerr++; $display("FAIL pre_done: count=%0d done=%b want 255/0", count, done); end
      end
    end
    in_valid = 1'b0;
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL done_rise: got %b want 1", done); end
    nvec++; if (count !== 9'd256) begin nerr++; $display("FAIL done_count: got %0d want 256", count); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL done_in_ready: got %b want 0", in_ready); end
    for (int a = 0; a < 256; a++) begin
      rd_en   = 1'b1;
      rd_addr = a[7:0];
      tick;
      rd_en = 1'b0;
      nvec++;
      if (rd_valid !== 1'b1 || rd_data !== 26'(a)) begin
        nerr++; $display("FAIL readback_%0d: rd_valid=%b rd_data=%0d want 1/%0d", a, rd_valid, rd_data, a);
      end
    end
    tick;
    nvec++; if (rd_valid !== 1'b0 || rd_data !== 26'd255) begin nerr++; $display("FAIL rd_hold: rd_valid=%b rd_data=%0d want 0/255", rd_valid, rd_data); end
  endtask

  task automatic test_overrun;
    in_valid = 1'b1;
    in_data  = 26'h155_5555;
    tick; tick; tick;
    in_valid = 1'b0;
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun_set: got %b want 1", overrun); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL overrun_in_ready: got %b want 0", in_ready); end
    rd_en = 1'b1; rd_addr = 8'd0;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data !== 26'd0) begin nerr++; $display("FAIL overrun_mem0: got %h want 0", rd_data); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    nvec++; if (overrun !== 1'b0 || done !== 1'b0 || count !== 9'd0) begin
      nerr++; $display("FAIL overrun_clear: overrun=%b done=%b count=%0d want 0/0/0", overrun, done, count);
    end
  endtask

  task automatic test_skip10;
    start10 = 1'b1;
    tick;
    start10 = 1'b0;
    nvec++; if (in_ready10 !== 1'b1 || count10 !== 9'd0) begin nerr++; $display("FAIL skip_enter: in_ready=%b count=%0d want 1/0", in_ready10, count10); end
    for (int i = 0; i < 266; i++) begin
      in_valid = 1'b1;
      in_data  = 26'(1000 + i);
      tick;
      if (i == 9) begin
        nvec++; if (count10 !== 9'd0) begin nerr++; $display("FAIL skip_no_store: count=%0d want 0", count10); end
      end
    end
    in_valid = 1'b0;
    nvec++; if (done10 !== 1'b1 || count10 !== 9'd256) begin nerr++; $display("FAIL skip_done: done=%b count=%0d want 1/256", done10, count10); end
    nvec++; if (count !== 9'd0 || done !== 1'b0) begin nerr++; $display("FAIL idle_ignores: count=%0d done=%b want 0/0", count, done); end
    rd_en = 1'b1; rd_addr = 8'd0;
    tick;
    nvec++; if (rd_data10 !== 26'd1010) begin nerr++; $display("FAIL skip_mem0: got %0d want 1010", rd_data10); end
    rd_addr = 8'd1;
    tick;
    nvec++; if (rd_data10 !== 26'd1011) begin nerr++; $display("FAIL skip_mem1: got %0d want 1011", rd_data10); end
    rd_addr = 8'd255;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data10 !== 26'd1265 || rd_valid10 !== 1'b1) begin nerr++; $display("FAIL skip_mem255: got %0d/%b want 1265/1", rd_data10, rd_valid10); end
  endtask

  task automatic test_throttle;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b0;
      if (i == 10) start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      if (i == 5) begin
        nvec++; if (count !== 9'd5) begin nerr++; $display("FAIL throttle_idle_count: got %0d want 5", count); end
      end
      in_valid = 1'b1;
      in_data  = 26'h3FF_FFFF - 26'(i);
      tick;
      in_valid = 1'b0;
      if (i == 5) begin
        nvec++; if (count !== 9'd6) begin nerr++; $display("FAIL throttle_accept_count: got %0d want 6", count); end
      end
    end
    nvec++; if (done !== 1'b1 || count !== 9'd256) begin nerr++; $display("FAIL throttle_done: done=%b count=%0d want 1/256", done, count); end
    rd_en = 1'b1; rd_addr = 8'd0;
    tick;
    nvec++; if (rd_data !== 26'h3FF_FFFF) begin nerr++; $display("FAIL throttle_mem0: got %h want 3ffffff", rd_data); end
    rd_addr = 8'd77;
    tick;
    nvec++; if (rd_data !== 26'h3FF_FFB2) begin nerr++; $display("FAIL throttle_mem77: got %h want 3ffffb2", rd_data); end
    rd_addr = 8'd255;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data !== 26'h3FF_FF00) begin nerr++; $display("FAIL throttle_mem255: got %h want 3ffff00", rd_data); end
  endtask

  task automatic test_clear_mid;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 26'h200_0000 + 26'(i);
      tick;
    end
    nvec++; if (count !== 9'd100) begin nerr++; $display("FAIL clear_pre_count: got %0d want 100", count); end
    in_data = 26'h0AB_CDEF;
    clear = 1'b1;
    start = 1'b1;
    tick;
    in_valid = 1'b0; clear = 1'b0; start = 1'b0;
    nvec++; if (in_ready !== 1'b0 || count !== 9'd0 || done !== 1'b0) begin
      nerr++; $display("FAIL clear_idle: in_ready=%b count=%0d done=%b want 0/0/0", in_ready, count, done);
    end
    rd_en = 1'b1; rd_addr = 8'd100;
    tick;
    nvec++; if (rd_data !== 26'h3FF_FF9B) begin nerr++; $display("FAIL clear_no_write100: got %h want 3ffff9b", rd_data); end
    rd_addr = 8'd99;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data !== 26'h200_0063) begin nerr++; $display("FAIL clear_mem99: got %h want 2000063", rd_data); end
    start = 1'b1;
    tick;
    start = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd0;
    in_valid = 1'b1; in_data = 26'h123_4567;
    tick;
    rd_en = 1'b0; in_valid = 1'b0;
    nvec++; if (rd_data !== 26'h200_0000) begin nerr++; $display("FAIL read_before_write: got %h want 2000000", rd_data); end
    nvec++; if (count !== 9'd1) begin nerr++; $display("FAIL fresh_run_count: got %0d want 1", count); end
    rd_en = 1'b1; rd_addr = 8'd0;
    tick;
    nvec++; if (rd_data !== 26'h123_4567) begin nerr++; $display("FAIL fresh_run_mem0: got %h want 1234567", rd_data); end
    rd_addr = 8'd1;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data !== 26'h200_0001) begin nerr++; $display("FAIL fresh_run_mem1: got %h want 2000001", rd_data); end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = 26'h050_0000 + 26'(i);
      tick;
    end
    in_valid = 1'b0;
    nvec++; if (count !== 9'd50) begin nerr++; $display("FAIL reset_mid_pre_count: got %0d want 50", count); end
    rd_en = 1'b1; rd_addr = 8'd3;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_valid !== 1'b1 || rd_data !== 26'h050_0003) begin nerr++; $display("FAIL reset_mid_pre_read: %b/%h want 1/0500003", rd_valid, rd_data); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    nvec++; if (in_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 26'd0) begin
      nerr++; $display("FAIL reset_mid_port: in_ready=%b rd_valid=%b rd_data=%h want 0/0/0", in_ready, rd_valid, rd_data);
    end
    nvec++; if (count !== 9'd0 || done !== 1'b0 || overrun !== 1'b0) begin
      nerr++; $display("FAIL reset_mid_status: count=%0d done=%b overrun=%b want 0/0/0", count, done, overrun);
    end
`ifdef FIR_CAP_CHECKSUM_EN
    nvec++; if (checksum !== 26'd0) begin nerr++; $display("FAIL reset_mid_checksum: got %h want 0", checksum); end
`endif
    rd_en = 1'b1; rd_addr = 8'd10;
    tick;
    rd_en = 1'b0;
    nvec++; if (rd_data !== 26'h050_000A || rd_valid !== 1'b1) begin nerr++; $display("FAIL reset_mid_mem10: %h/%b want 050000a/1", rd_data, rd_valid); end
  endtask

  initial begin
    test_reset;
    test_skip0_stream;
    test_overrun;
    test_skip10;
    test_throttle;
    test_clear_mid;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fir_out_capture.md
Name: fir_out_capture

Overview:
- Capture engine at the output end of the FIR datapath.
- Accepts the filter's 26-bit output stream through a valid/ready handshake.
- Discards a programmable number of pipeline-fill samples, then writes the next DEPTH samples into an internal output memory.
- Provides a registered readback port so a host or checker can read results by address.

Parameters:
- DATA_W, 26, width of one filter output sample.
- DEPTH, 256, number of samples stored per capture run.
- ADDR_W, 8, memory address width; must satisfy 2**ADDR_W == DEPTH.
- SKIP, 0, number of accepted samples discarded after start, before the first store (0..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE.
- clear  in  1  one-cycle pulse; aborts or finishes a run and returns to IDLE.
- in_valid  in  1  filter output sample present.
- in_data  in  DATA_W  filter output sample.
- in_ready  out  1  block accepts in_data this cycle.
- rd_en  in  1  readback request.
- rd_addr  in  ADDR_W  readback address.
- rd_data  out  DATA_W  readback word, valid one cycle after rd_en.
- rd_valid  out  1  qualifies rd_data.
- count  out  ADDR_W+1  number of words stored in the current run.
- done  out  1  DEPTH words stored.
- overrun  out  1  sticky; sample offered while not ready outside IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - in_ready, rd_data, rd_valid, count, done and overrun are all 0.
  - Memory contents are not reset.
- States: IDLE, SKIP, CAPTURE, DONE.
- IDLE:
  - in_ready=0.
  - start moves to SKIP if SKIP>0, otherwise to CAPTURE.
  - Entering a run clears count and the write address.
- SKIP:
  - in_ready=1.
  - Each accept (in_valid && in_ready) increments the skip counter.
  - The SKIP-th accept moves to CAPTURE; skipped data is discarded.
- CAPTURE:
  - in_ready=1.
  - Each accept writes mem[wr_addr] and increments wr_addr and count.
  - The accept that makes count==DEPTH moves to DONE; done=1 from the next cycle.
  - wr_addr wraps to 0 but is not reused in that run.
- DONE:
  - in_ready=0; done stays 1 until clear or reset.
- Overrun:
  - in_valid=1 while in DONE sets overrun, and no write occurs.
  - in_valid in IDLE is ignored silently.
- clear:
  - From any state, goes to IDLE next cycle and zeroes count, done and overrun.
  - Takes priority over start and over an accept in the same cycle; that sample is not stored.
- start outside IDLE is ignored.
- Readback:
  - Available in every state.
  - rd_en in cycle N gives rd_data=mem[rd_addr] and rd_valid=1 in cycle N+1.
  - rd_valid=0 otherwise; rd_data holds its last value.
  - A read and a write to the same address in one cycle returns the old data (read-before-write).
- Mid-run reset behaves identically to clear, plus clears rd_valid.
- Memory is a synchronous simple dual-port array, 1 write and 1 read port.

Optional Feature:
- Macro FIR_CAP_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_W-1:0].
  - checksum is the XOR of every word stored in the current run.
  - It updates in the cycle after each write and is cleared by reset, clear and start-accept.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package fir_cap_pkg:
  - State enum (IDLE, SKIP, CAPTURE, DONE).
  - Default DATA_W/DEPTH/ADDR_W constants.
  - Sample typedef logic [DATA_W-1:0].
- Sub-module fir_cap_ram:
  - Parameterised DATA_W x DEPTH simple dual-port synchronous RAM.
  - Read-before-write, registered read.
  - Holds the array inside the capture block.

Test Plan:
- SKIP=0, start, stream 0..255 back-to-back:
  - done rises the cycle after the 256th accept; count=256.
  - Readback of addr i returns i, rd_valid one cycle after rd_en.
- SKIP=10, stream 1000..1265:
  - mem[0]=1010 and mem[255]=1265; the first 10 samples are absent.
- in_valid asserted every third cycle, data 26'h3FFFFFF-i:
  - Contents match the unthrottled case.
  - count advances only on accepts.
- After done, hold in_valid=1, in_data=26'h155_5555 for 3 cycles:
  - overrun=1, in_ready=0, mem[0] unchanged.
  - A subsequent clear gives overrun=0 and done=0.
- At count=100, assert clear and in_valid together, with start also pulsed:
  - State goes to IDLE, count=0, no write to addr 100.
  - A second start begins a fresh run at addr 0.
- At count=50, assert reset:
  - All outputs read 0.
  - Readback of addr 10 still returns the previously stored value.
  - With FIR_CAP_CHECKSUM_EN defined, checksum resets to 0.
